// File: rtl/mmio_arbiter_pkg.sv
// Shared types and constants for the MMIO arbiter.
// Holds the FSM state enum, default sizing and a one-hot decode helper.
package mmio_arb_pkg;

    localparam int NUM_REQ_DEF = 4;

    // Port block decodes 2**PORT_EXPONENT ports, two addresses per port.
    localparam int PORT_EXPONENT  = 4;
    localparam int PORT_LIMIT_DEF = 2 * (2 ** PORT_EXPONENT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Index of the set bit in a one-hot vector (0 when empty).
    function automatic int oh_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mmio_arbiter_if.sv
// Bundle between NUM_REQ requesters, the arbiter and the MMIO port block.
// slave: arbiter view; master: requester/port-block view.
interface mmio_arbiter_if
    import mmio_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
);

    // Requester side
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       req_we;
    logic [NUM_REQ-1:0][15:0] req_addr;
    logic [NUM_REQ-1:0][15:0] req_wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic [15:0]              rdata;
    logic                     err;

    // MMIO port block side
    logic                     mmio_read;
    logic                     mmio_write;
    logic [15:0]              mmio_addr;
    logic [15:0]              mmio_wdata;
    logic [15:0]              mmio_rdata;

    modport slave (
        input  req,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output gnt,
        output done,
        output rdata,
        output err,
        output mmio_read,
        output mmio_write,
        output mmio_addr,
        output mmio_wdata,
        input  mmio_rdata
    );

    modport master (
        output req,
        output req_we,
        output req_addr,
        output req_wdata,
        input  gnt,
        input  done,
        input  rdata,
        input  err,
        input  mmio_read,
        input  mmio_write,
        input  mmio_addr,
        input  mmio_wdata,
        output mmio_rdata
    );

endinterface

// File: rtl/mmio_arbiter_rr_arbiter.sv
// Combinational round-robin winner select: searches from last_winner+1 up with wrap.
// Ports: req (in), last_winner (in), winner (one-hot out). PRIO_EN makes req[0] always win.
module rr_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    parameter bit  PRIO_EN = 1'b0,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_winner,
    output logic [NUM_REQ-1:0] winner
);

    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (PRIO_EN && req[0]) begin
            winner[0] = 1'b1;
        end else begin
            // k == NUM_REQ revisits last_winner itself, so a lone
            // repeat requester is still served.
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = int'(last_winner) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                // With priority on, requester 0 is handled above only.
                if (!found && req[IW'(idx)] &&
                    !(PRIO_EN && (idx == 0))) begin
                    winner[IW'(idx)] = 1'b1;
                    found            = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Shares one MMIO port block among NUM_REQ requesters: IDLE -> ACCESS -> RESP.
// Ports: clk, rst (sync, active-high), bus (mmio_arbiter_if.slave): req/we/addr/wdata in,
// gnt/done/rdata/err out, mmio_read/write/addr/wdata out, mmio_rdata in.
// Optional macro MMIO_ARB_PRIORITY_EN: requester 0 (CPU) wins whenever it requests.
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int PORT_LIMIT = PORT_LIMIT_DEF
) (
    input logic            clk,
    input logic            rst,
    mmio_arbiter_if.slave  bus
);

    localparam int          IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [16:0] LIMIT = 17'(PORT_LIMIT);

`ifdef MMIO_ARB_PRIORITY_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      win_q, win_d;
    logic               we_q, we_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [IW-1:0]      win_idx;
    logic               in_range;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PRIO_EN (PRIO_EN)
    ) u_rr (
        .req         (bus.req),
        .last_winner (last_q),
        .winner      (win_oh)
    );

    assign win_idx  = IW'(oh_to_idx(32'(win_oh)));
    assign in_range = ({1'b0, addr_q} < LIMIT);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    win_d   = win_idx;
                    we_d    = bus.req_we[win_idx];
                    addr_d  = bus.req_addr[win_idx];
                    wdata_d = bus.req_wdata[win_idx];
                end
            end
            ST_ACCESS: begin
                // Port block answers during the strobe cycle; capture it
                // here so it is presented alongside done.
                rdata_d = (in_range && !we_q) ? bus.mmio_rdata : 16'h0000;
                err_d   = !in_range;
            end
            ST_RESP: begin
                last_d = win_q;
            end
            default: ;
        endcase
    end

    // Outputs; reset gates everything in the same cycle
    always_comb begin
        bus.gnt        = '0;
        bus.done       = '0;
        bus.mmio_read  = 1'b0;
        bus.mmio_write = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    bus.gnt = win_oh;
                end
                ST_ACCESS: begin
                    bus.mmio_read  = in_range && !we_q;
                    bus.mmio_write = in_range && we_q;
                end
                ST_RESP: begin
                    bus.done[win_q] = 1'b1;
                end
                default: ;
            endcase
        end
        bus.mmio_addr  = rst ? 16'h0000 : addr_q;
        bus.mmio_wdata = rst ? 16'h0000 : wdata_q;
        bus.rdata      = rst ? 16'h0000 : rdata_q;
        bus.err        = rst ? 1'b0 : err_q;
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_mmio_arbiter;
    import mmio_arb_pkg::*;

    localparam int N   = 4;
    localparam int LIM = PORT_LIMIT_DEF;

`ifdef MMIO_ARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mmio_arbiter_if #(.NUM_REQ(N)) bus();

    mmio_arbiter #(
        .NUM_REQ    (N),
        .PORT_LIMIT (LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int m_last;

    // Who should win next, straight from the arbitration rules.
    function automatic int pick(input logic [N-1:0] r, input int last);
        if (PRIO && r[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (PRIO && i == 0) continue;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic idle_inputs;
        bus.req        = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mmio_rdata = '0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = N - 1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        bus.req = '1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (bus.gnt !== '0) begin
            n_err++; $display("FAIL reset_gnt got %b want 0", bus.gnt);
        end
        n_vec++;
        if (bus.done !== '0) begin
            n_err++; $display("FAIL reset_done got %b want 0", bus.done);
        end
        n_vec++;
        if (bus.mmio_read !== 1'b0 || bus.mmio_write !== 1'b0) begin
            n_err++;
            $display("FAIL reset_strobe got r%b w%b want 0",
                     bus.mmio_read, bus.mmio_write);
        end
        n_vec++;
        if (bus.mmio_addr !== 16'h0 || bus.mmio_wdata !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mmio got %h/%h want 0/0",
                     bus.mmio_addr, bus.mmio_wdata);
        end
        n_vec++;
        if (bus.rdata !== 16'h0 || bus.err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_resp got %h/%b want 0/0", bus.rdata, bus.err);
        end
    endtask

    task automatic test_single_write;
        do_reset();
        @(negedge clk);
        bus.req          = 4'b0100;
        bus.req_we[2]    = 1'b1;
        bus.req_addr[2]  = 16'h0003;
        bus.req_wdata[2] = 16'hBEEF;
        bus.req_addr[1]  = 16'h0007;
        #1;
        n_vec++;
        if (bus.gnt !== 4'b0100) begin
            n_err++; $display("FAIL wr_gnt got %b want 0100", bus.gnt);
        end
        @(negedge clk);
        bus.req = '0;
        #1;
        n_vec++;
        if (bus.mmio_write !== 1'b1 || bus.mmio_read !== 1'b0) begin
            n_err++;
            $display("FAIL wr_strobe got r%b w%b want r0 w1",
                     bus.mmio_read, bus.mmio_write);
        end
        n_vec++;
        if (bus.mmio_addr !== 16'h0003 || bus.mmio_wdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL wr_bus got %h/%h want 0003/beef",
                     bus.mmio_addr, bus.mmio_wdata);
        end
        n_vec++;
        if (bus.gnt !== '0 || bus.done !== '0) begin
            n_err++;
            $display("FAIL wr_access_pulses got g%b d%b want 0", bus.gnt, bus.done);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (bus.done !== 4'b0100 || bus.err !== 1'b0) begin
            n_err++;
            $display("FAIL wr_done got %b err %b want 0100 err 0", bus.done, bus.err);
        end
        n_vec++;
        if (bus.mmio_write !== 1'b0) begin
            n_err++; $display("FAIL wr_strobe_len got %b want 0", bus.mmio_write);
        end
        m_last = 2;
    endtask

    task automatic test_rotation;
        int w;
        logic [N-1:0] exp;
        do_reset();
        w = -1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            bus.req = '1;
            #1;
            exp = '0;
            if (c % 3 == 0) begin
                w   = pick(bus.req, m_last);
                exp = oh(w);
            end
            if (c % 3 == 2) m_last = w;
            n_vec++;
            if (bus.gnt !== exp) begin
                n_err++;
                $display("FAIL rotation_gnt c%0d got %b want %b", c, bus.gnt, exp);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_out_of_range;
        do_reset();
        @(negedge clk);
        bus.req         = 4'b0010;
        bus.req_we[1]   = 1'b0;
        bus.req_addr[1] = 16'(LIM);
        #1;
        n_vec++;
        if (bus.gnt !== 4'b0010) begin
            n_err++; $display("FAIL oor_gnt got %b want 0010", bus.gnt);
        end
        @(negedge clk);
        bus.req        = '0;
        bus.mmio_rdata = 16'hFFFF;
        #1;
        n_vec++;
        if (bus.mmio_read !== 1'b0 || bus.mmio_write !== 1'b0) begin
            n_err++;
            $display("FAIL oor_strobe got r%b w%b want 0",
                     bus.mmio_read, bus.mmio_write);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (bus.done !== 4'b0010 || bus.err !== 1'b1 || bus.rdata !== 16'h0) begin
            n_err++;
            $display("FAIL oor_done got %b err %b rd %h want 0010 1 0000",
                     bus.done, bus.err, bus.rdata);
        end
        m_last = 1;
    endtask

    task automatic test_read_drop;
        do_reset();
        @(negedge clk);
        bus.req         = 4'b0001;
        bus.req_we[0]   = 1'b0;
        bus.req_addr[0] = 16'h0001;
        #1;
        n_vec++;
        if (bus.gnt !== 4'b0001) begin
            n_err++; $display("FAIL rd_gnt got %b want 0001", bus.gnt);
        end
        @(negedge clk);
        bus.req        = '0;
        bus.mmio_rdata = 16'h1234;
        #1;
        n_vec++;
        if (bus.mmio_read !== 1'b1 || bus.mmio_addr !== 16'h0001) begin
            n_err++;
            $display("FAIL rd_strobe got %b @%h want 1 @0001",
                     bus.mmio_read, bus.mmio_addr);
        end
        @(negedge clk);
        bus.mmio_rdata = 16'h0000;
        #1;
        n_vec++;
        if (bus.done !== 4'b0001 || bus.rdata !== 16'h1234 || bus.err !== 1'b0) begin
            n_err++;
            $display("FAIL rd_done got %b rd %h err %b want 0001 1234 0",
                     bus.done, bus.rdata, bus.err);
        end
        m_last = 0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        @(negedge clk);
        bus.req          = 4'b1000;
        bus.req_we[3]    = 1'b1;
        bus.req_addr[3]  = 16'h0005;
        bus.req_wdata[3] = 16'hA5A5;
        #1;
        n_vec++;
        if (bus.gnt !== 4'b1000) begin
            n_err++; $display("FAIL rmid_gnt got %b want 1000", bus.gnt);
        end
        @(negedge clk);
        bus.req = '0;
        rst     = 1'b1;
        #1;
        n_vec++;
        if (bus.mmio_write !== 1'b0 || bus.mmio_read !== 1'b0 || bus.done !== '0) begin
            n_err++;
            $display("FAIL rmid_strobe got w%b r%b d%b want 0",
                     bus.mmio_write, bus.mmio_read, bus.done);
        end
        @(negedge clk);
        rst             = 1'b0;
        m_last          = N - 1;
        bus.req         = 4'b0001;
        bus.req_we[0]   = 1'b0;
        bus.req_addr[0] = 16'h0002;
        #1;
        n_vec++;
        if (bus.gnt !== 4'b0001 || bus.done !== '0) begin
            n_err++;
            $display("FAIL rmid_idle got g%b d%b want 0001 0000", bus.gnt, bus.done);
        end
        @(negedge clk);
        bus.req = '0;
        #1;
        n_vec++;
        if (bus.mmio_read !== 1'b1 || bus.mmio_addr !== 16'h0002) begin
            n_err++;
            $display("FAIL rmid_next got %b @%h want 1 @0002",
                     bus.mmio_read, bus.mmio_addr);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (bus.done !== 4'b0001) begin
            n_err++; $display("FAIL rmid_done got %b want 0001", bus.done);
        end
        m_last = 0;
    endtask

    task automatic test_random;
        int           phase;
        int           w;
        logic         we_l;
        logic [15:0]  addr_l;
        logic [15:0]  wdata_l;
        logic [15:0]  rd_l;
        logic         inr;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_done;
        logic         e_rd;
        logic         e_wr;
        do_reset();
        phase = 0;
        w     = 0;
        we_l  = 1'b0;
        addr_l  = '0;
        wdata_l = '0;
        rd_l  = '0;
        inr   = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.req = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                bus.req_we[i]    = 1'($urandom_range(0, 1));
                bus.req_addr[i]  = ($urandom_range(0, 3) != 0)
                                   ? 16'($urandom_range(0, LIM + 8))
                                   : 16'($urandom);
                bus.req_wdata[i] = 16'($urandom);
            end
            bus.mmio_rdata = 16'($urandom);
            #1;
            e_gnt  = '0;
            e_done = '0;
            e_rd   = 1'b0;
            e_wr   = 1'b0;
            if (phase == 0) begin
                if (|bus.req) begin
                    w       = pick(bus.req, m_last);
                    e_gnt   = oh(w);
                    we_l    = bus.req_we[w];
                    addr_l  = bus.req_addr[w];
                    wdata_l = bus.req_wdata[w];
                    phase   = 1;
                end
            end else if (phase == 1) begin
                inr  = (int'(addr_l) < LIM);
                e_rd = inr && !we_l;
                e_wr = inr && we_l;
                rd_l = e_rd ? bus.mmio_rdata : 16'h0000;
                n_vec++;
                if (bus.mmio_addr !== addr_l || bus.mmio_wdata !== wdata_l) begin
                    n_err++;
                    $display("FAIL rand_bus c%0d got %h/%h want %h/%h", c,
                             bus.mmio_addr, bus.mmio_wdata, addr_l, wdata_l);
                end
                phase = 2;
            end else begin
                e_done = oh(w);
                n_vec++;
                if (bus.rdata !== rd_l || bus.err !== !inr) begin
                    n_err++;
                    $display("FAIL rand_resp c%0d got %h/%b want %h/%b", c,
                             bus.rdata, bus.err, rd_l, !inr);
                end
                m_last = w;
                phase  = 0;
            end
            n_vec++;
            if (bus.gnt !== e_gnt || bus.done !== e_done) begin
                n_err++;
                $display("FAIL rand_pulse c%0d got g%b d%b want g%b d%b", c,
                         bus.gnt, bus.done, e_gnt, e_done);
            end
            n_vec++;
            if (bus.mmio_read !== e_rd || bus.mmio_write !== e_wr) begin
                n_err++;
                $display("FAIL rand_strobe c%0d got r%b w%b want r%b w%b", c,
                         bus.mmio_read, bus.mmio_write, e_rd, e_wr);
            end
        end
        idle_inputs();
    endtask

    task automatic test_priority_hold;
        int w;
        logic [N-1:0] exp;
        do_reset();
        w = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.req = 4'b1011;
            #1;
            exp = '0;
            if (c % 3 == 0) begin
                w   = pick(bus.req, m_last);
                exp = oh(w);
            end
            if (c % 3 == 2) m_last = w;
            n_vec++;
            if (bus.gnt !== exp) begin
                n_err++;
                $display("FAIL hold1011_gnt c%0d got %b want %b", c, bus.gnt, exp);
            end
        end
        bus.req = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_rotation();
        test_out_of_range();
        test_read_drop();
        test_reset_mid();
        test_priority_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
